// File: rtl/mrv32_pkg.sv
// Shared widths, FSM/owner encodings and the memory request payload for the memory-port arbiter.
package mrv32_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WSTRB_W  = 4;
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_WAIT_RSP = 2'd2,
    ARB_RESP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic               wen;
    logic [WSTRB_W-1:0] wstrb;
    logic [DATA_W-1:0]  wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant: LSU wins unless IF is waiting and the LSU streak has reached its limit.
module arb_pick
  import mrv32_pkg::*;
#(
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic                en_i,
  input  logic                if_valid_i,
  input  logic                lsu_valid_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                grant_if_c_o,
  output logic                grant_lsu_c_o
);

  logic if_starving;

  always_comb begin
    if_starving   = if_valid_i && (streak_i == STREAK_W'(MAX_LSU_STREAK));
    grant_lsu_c_o = en_i && lsu_valid_i && !if_starving;
    grant_if_c_o  = en_i && if_valid_i && !grant_lsu_c_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the core memory port between instruction fetch and load/store.
// One transaction in flight; LSU has priority, bounded by a streak limit so IF cannot starve.
module mem_arbiter
  import mrv32_pkg::*;
#(
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req_valid,
  output logic               if_req_ready,
  input  logic [ADDR_W-1:0]  if_req_addr,
  output logic               if_rsp_valid,
  output logic [DATA_W-1:0]  if_rsp_rdata,
  output logic               if_rsp_err,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [ADDR_W-1:0]  lsu_req_addr,
  input  logic               lsu_req_wen,
  input  logic [WSTRB_W-1:0] lsu_req_wstrb,
  input  logic [DATA_W-1:0]  lsu_req_wdata,
  output logic               lsu_rsp_valid,
  output logic [DATA_W-1:0]  lsu_rsp_rdata,
  output logic               lsu_rsp_err,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic               mem_req_wen,
  output logic [WSTRB_W-1:0] mem_req_wstrb,
  output logic [DATA_W-1:0]  mem_req_wdata,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rsp_rdata,
  input  logic               mem_rsp_err,
  output logic               busy
);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  mem_req_t            req_q, req_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                idle;
  logic                grant_if_c, grant_lsu_c;

  assign idle = (state_q == ARB_IDLE);

  arb_pick #(
    .MAX_LSU_STREAK(MAX_LSU_STREAK)
  ) u_pick (
    .en_i         (idle),
    .if_valid_i   (if_req_valid),
    .lsu_valid_i  (lsu_req_valid),
    .streak_i     (streak_q),
    .grant_if_c_o (grant_if_c),
    .grant_lsu_c_o(grant_lsu_c)
  );

  // Next-state, request latch, response latch and streak bookkeeping
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    streak_d = streak_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_lsu_c) begin
          req_d   = '{addr: lsu_req_addr, wen: lsu_req_wen,
                      wstrb: lsu_req_wstrb, wdata: lsu_req_wdata};
          owner_d = OWN_LSU;
          state_d = ARB_ISSUE;
          if (!if_req_valid) begin
            streak_d = '0;
          end else if (streak_q != STREAK_W'(MAX_LSU_STREAK)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (grant_if_c) begin
          req_d    = '{addr: if_req_addr, wen: 1'b0,
                       wstrb: {WSTRB_W{1'b1}}, wdata: '0};
          owner_d  = OWN_IF;
          state_d  = ARB_ISSUE;
          streak_d = '0;
        end
      end
      ARB_ISSUE: begin
        if (mem_req_ready) begin
          state_d = ARB_WAIT_RSP;
        end
      end
      ARB_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rdata_d = mem_rsp_rdata;
          err_d   = mem_rsp_err;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IF;
      req_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      streak_q <= streak_d;
    end
  end

  assign if_req_ready  = grant_if_c;
  assign lsu_req_ready = grant_lsu_c;

  assign mem_req_valid = (state_q == ARB_ISSUE);
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wen   = req_q.wen;
  assign mem_req_wstrb = req_q.wstrb;
  assign mem_req_wdata = req_q.wdata;

  // Store responses carry no load data
  assign if_rsp_valid  = (state_q == ARB_RESP) && (owner_q == OWN_IF);
  assign lsu_rsp_valid = (state_q == ARB_RESP) && (owner_q == OWN_LSU);
  assign if_rsp_rdata  = rdata_q;
  assign lsu_rsp_rdata = req_q.wen ? '0 : rdata_q;
  assign if_rsp_err    = err_q;
  assign lsu_rsp_err   = err_q;

  assign busy = !idle;

endmodule
